cve2_trace_buffer: RTL

CVE2_TRACE_BUFFER -- requirements
Module: cve2_trace_buffer

---
 rtl/cve2_trace_buffer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cve2_trace_buffer.sv
// cve2_trace_buffer: triggered capture of retired-instruction records with post-trigger window and FIFO readout.
module cve2_trace_buffer #(
  parameter int Depth    = 16,
  parameter int PostTrig = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       rvfi_valid_i,
  input  logic [31:0]                rvfi_pc_rdata_i,
  input  logic [31:0]                rvfi_insn_i,
  input  logic                       rvfi_trap_i,
  input  logic [4:0]                 rvfi_rd_addr_i,
  input  logic [31:0]                rvfi_rd_wdata_i,
  input  logic                       arm_i,
  input  logic                       abort_i,
  input  logic                       wrap_mode_i,
  input  logic                       trig_en_i,
  input  logic [31:0]                trig_pc_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [31:0]                rd_pc_o,
  output logic [31:0]                rd_insn_o,
  output logic                       rd_trap_o,
  output logic [4:0]                 rd_rd_addr_o,
  output logic [31:0]                rd_rd_wdata_o,
  output logic [1:0]                 state_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       overflow_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);

  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, TRIGGERED = 2'b10, DONE = 2'b11} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rec_t;

  rec_t          mem_q [Depth];
  rec_t          rd_rec;
  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, post_q, post_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, capt, trig, we, stop_full;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    post_d     = post_q;
    full       = count_q == CW'(Depth);
    capt       = rvfi_valid_i && (state_q == ARMED || state_q == TRIGGERED);
    trig       = rvfi_valid_i && state_q == ARMED && (!trig_en_i || rvfi_pc_rdata_i == trig_pc_i);
    we         = capt && (!full || wrap_mode_i) && !abort_i;
    stop_full  = 1'b0;
    if (abort_i) begin
      state_d    = IDLE;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      post_d     = '0;
    end else begin
      overflow_d = overflow_q | (capt && full);
      wptr_d     = we ? wptr_q + 1'b1 : wptr_q;
      rptr_d     = (we && full) ? rptr_q + 1'b1 : rptr_q;
      count_d    = (we && !full) ? count_q + 1'b1 : count_q;
      // In stop mode a full buffer ends the capture window early
      stop_full  = !wrap_mode_i && count_d == CW'(Depth);
      if (state_q == IDLE && arm_i) begin
        state_d    = ARMED;
        wptr_d     = '0;
        rptr_d     = '0;
        count_d    = '0;
        overflow_d = 1'b0;
      end
      if (trig) begin
        post_d  = AW'(PostTrig);
        state_d = (PostTrig == 0 || stop_full) ? DONE : TRIGGERED;
      end
      if (state_q == TRIGGERED && capt) begin
        post_d  = post_q - 1'b1;
        state_d = (post_q == AW'(1) || stop_full) ? DONE : TRIGGERED;
      end
      if (state_q == DONE) begin
        state_d = (count_q == '0) ? IDLE : DONE;
        rptr_d  = (rd_valid_o && rd_ready_i) ? rptr_q + 1'b1 : rptr_q;
        count_d = (rd_valid_o && rd_ready_i) ? count_q - 1'b1 : count_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      post_q     <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      post_q     <= post_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wptr_q] <= {rvfi_pc_rdata_i, rvfi_insn_i, rvfi_trap_i, rvfi_rd_addr_i, rvfi_rd_wdata_i};
  end

  assign rd_valid_o    = state_q == DONE && count_q != '0;
  assign rd_rec        = rd_valid_o ? mem_q[rptr_q] : '0;
  assign rd_pc_o       = rd_rec.pc;
  assign rd_insn_o     = rd_rec.insn;
  assign rd_trap_o     = rd_rec.trap;
  assign rd_rd_addr_o  = rd_rec.rd_addr;
  assign rd_rd_wdata_o = rd_rec.rd_wdata;
  assign state_o       = state_q;
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;
endmodule
